// File: rtl/step_sequencer_core.sv
// 16-step toggle pattern with a tempo-driven playhead, per-step strobe and timed gate.
// Define SEQ_SWING_EN to build swing timing (even steps long, odd steps short).
module step_sequencer_core #(
  parameter int unsigned TICKS_PER_STEP = 1_500_000,
  parameter int unsigned GATE_TICKS     = 750_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  button_index,
  input  logic        button_pressed,
  input  logic        run,
  input  logic        clear,
  input  logic        rewind,
  output logic [15:0] pattern,
  output logic [3:0]  playhead,
  output logic        step_pulse,
  output logic        gate
);

`ifdef SEQ_SWING_EN
  localparam int unsigned SWING   = TICKS_PER_STEP >> 2;
  localparam int unsigned MAX_LEN = TICKS_PER_STEP + SWING;
`else
  localparam int unsigned MAX_LEN = TICKS_PER_STEP;
`endif
  localparam int unsigned TICK_W  = $clog2(MAX_LEN);

  localparam logic [TICK_W-1:0] GATE_LAST = TICK_W'(GATE_TICKS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         pattern_q, pattern_d;
  logic [3:0]          playhead_q, playhead_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                pulse_q, pulse_d;
  logic                gate_q, gate_d;
  logic [TICK_W-1:0]   last_tick;

  // Final tick of the step currently under the playhead.
`ifdef SEQ_SWING_EN
  assign last_tick = playhead_q[0] ? TICK_W'(TICKS_PER_STEP - SWING - 1)
                                   : TICK_W'(TICKS_PER_STEP + SWING - 1);
`else
  assign last_tick = TICK_W'(TICKS_PER_STEP - 1);
`endif

  // Edit path runs regardless of play state; clear beats a same-cycle press.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    pattern_d = pattern_q;
    if (clear) begin
      pattern_d = '0;
    end else if (button_pressed) begin
      pattern_d[button_index] = ~pattern_q[button_index];
    end
  end

  // Gate values read pattern_q, so a same-cycle toggle never affects the gate.
  always_comb begin
    state_d    = state_q;
    playhead_d = playhead_q;
    tick_d     = tick_q;
    pulse_d    = 1'b0;
    gate_d     = gate_q;

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        gate_d = 1'b0;
        if (rewind) begin
          playhead_d = '0;
        end
        if (run) begin
          state_d = PLAY;
          pulse_d = 1'b1;
          gate_d  = pattern_q[playhead_d];
        end
      end

      PLAY: begin
        if (!run) begin
          state_d = IDLE;
          tick_d  = '0;
          gate_d  = 1'b0;
          if (rewind) begin
            playhead_d = '0;
          end
        end else if (rewind) begin
          playhead_d = '0;
          tick_d     = '0;
          pulse_d    = 1'b1;
          gate_d     = pattern_q[0];
        end else if (tick_q == last_tick) begin
          playhead_d = playhead_q + 4'd1;
          tick_d     = '0;
          pulse_d    = 1'b1;
          gate_d     = pattern_q[playhead_d];
        end else begin
          tick_d = tick_q + 1'b1;
          if (tick_q == GATE_LAST) begin
            gate_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pattern_q  <= '0;
      playhead_q <= '0;
      tick_q     <= '0;
      pulse_q    <= 1'b0;
      gate_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      playhead_q <= playhead_d;
      tick_q     <= tick_d;
      pulse_q    <= pulse_d;
      gate_q     <= gate_d;
    end
  end

  assign pattern    = pattern_q;
  assign playhead   = playhead_q;
  assign step_pulse = pulse_q;
  assign gate       = gate_q;

endmodule

// File: tb/tb_step_sequencer_core.sv
// Self-checking bench for step_sequencer_core: a timeline model (step start times,
// step lengths, gate windows) predicts strobe, playhead and gate every cycle.
module tb_step_sequencer_core;

  localparam int TPS  = 8;
  localparam int GATE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  button_index;
  logic        button_pressed;
  logic        run;
  logic        clear;
  logic        rewind;
  logic [15:0] pattern;
  logic [3:0]  playhead;
  logic        step_pulse;
  logic        gate;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_pat = '0;
  logic [3:0]  cur_ph  = '0;

  step_sequencer_core #(
    .TICKS_PER_STEP(TPS),
    .GATE_TICKS    (GATE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_index  (button_index),
    .button_pressed(button_pressed),
    .run           (run),
    .clear         (clear),
    .rewind        (rewind),
    .pattern       (pattern),
    .playhead      (playhead),
    .step_pulse    (step_pulse),
    .gate          (gate)
  );

  always #5 clk = ~clk;

  function automatic int step_len(input int ph);
`ifdef SEQ_SWING_EN
    return (ph % 2 == 0) ? TPS + TPS / 4 : TPS - TPS / 4;
`else
    return TPS;
`endif
  endfunction

  // Cycle index (1 = first edge after run rises) at which step k starts, from step 0.
  function automatic int step_start_cycle(input int k);
    int t = 1;
    for (int i = 0; i < k; i++) t += step_len(i % 16);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    button_index   = 4'(idx);
    button_pressed = 1'b1;
    tick();
    button_pressed = 1'b0;
    exp_pat[idx]   = ~exp_pat[idx];
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    exp_pat = '0;
  endtask

  // Raises run and predicts every cycle from step start times and gate windows.
  task automatic watch_play(input int n, input logic [3:0] start_ph, input logic [15:0] pat,
                            input int rewind_at, output logic [3:0] end_ph);
    int   ph, step_start, next_pulse;
    logic exp_pulse, exp_gate;
    ph         = int'(start_ph);
    step_start = 1;
    next_pulse = 1 + step_len(ph);
    run        = 1'b1;
    for (int c = 1; c <= n; c++) begin
      rewind = (c == rewind_at);
      tick();
      exp_pulse = 1'b0;
      if (c == 1) begin
        exp_pulse = 1'b1;
      end else if (c == rewind_at) begin
        ph = 0; step_start = c; next_pulse = c + step_len(0); exp_pulse = 1'b1;
      end else if (c == next_pulse) begin
        ph = (ph + 1) % 16; step_start = c; next_pulse = c + step_len(ph); exp_pulse = 1'b1;
      end
      exp_gate = pat[ph] && ((c - step_start) < GATE);
      n_checks++;
      if (step_pulse !== exp_pulse) $display("FAIL play_pulse c=%0d: got %b expected %b", c, step_pulse, exp_pulse);
      else n_pass++;
      n_checks++;
      if (playhead !== 4'(ph)) $display("FAIL play_playhead c=%0d: got %0d expected %0d", c, playhead, ph);
      else n_pass++;
      n_checks++;
      if (gate !== exp_gate) $display("FAIL play_gate c=%0d ph=%0d: got %b expected %b", c, ph, gate, exp_gate);
      else n_pass++;
    end
    rewind = 1'b0;
    end_ph = 4'(ph);
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (pattern !== 16'h0) $display("FAIL reset_pattern: got %h expected 0000", pattern); else n_pass++;
    n_checks++; if (playhead !== 4'd0) $display("FAIL reset_playhead: got %0d expected 0", playhead); else n_pass++;
    n_checks++; if (step_pulse !== 1'b0) $display("FAIL reset_pulse: got %b expected 0", step_pulse); else n_pass++;
    n_checks++; if (gate !== 1'b0) $display("FAIL reset_gate: got %b expected 0", gate); else n_pass++;
    #10 rst_n = 1'b1;
    tick();
    tick();
    n_checks++; if (step_pulse !== 1'b0 || gate !== 1'b0) $display("FAIL idle_after_reset: pulse %b gate %b expected 0 0", step_pulse, gate); else n_pass++;
  endtask

  task automatic test_toggle();
    press(5);
    n_checks++; if (pattern !== 16'h0020) $display("FAIL toggle_5: got %h expected 0020", pattern); else n_pass++;
    press(5);
    n_checks++; if (pattern !== 16'h0000) $display("FAIL toggle_5_again: got %h expected 0000", pattern); else n_pass++;
    press(15);
    n_checks++; if (pattern !== 16'h8000) $display("FAIL toggle_15: got %h expected 8000", pattern); else n_pass++;
    clear = 1'b1; button_pressed = 1'b1; button_index = 4'd3;
    tick();
    clear = 1'b0; button_pressed = 1'b0; exp_pat = '0;
    n_checks++; if (pattern !== 16'h0000) $display("FAIL clear_beats_press: got %h expected 0000", pattern); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      logic do_clr, do_prs;
      int   idx;
      do_clr = ($urandom_range(0, 7) == 0);
      do_prs = ($urandom_range(0, 3) != 0);
      idx    = int'($urandom_range(0, 15));
      clear = do_clr; button_pressed = do_prs; button_index = 4'(idx);
      tick();
      clear = 1'b0; button_pressed = 1'b0;
      if (do_clr) exp_pat = '0;
      else if (do_prs) exp_pat[idx] = ~exp_pat[idx];
      n_checks++; if (pattern !== exp_pat) $display("FAIL random_edit %0d: got %h expected %h", i, pattern, exp_pat); else n_pass++;
    end
    do_clear();
  endtask

  task automatic test_play();
    logic [3:0] ph;
    press(0);
    press(2);
    n_checks++; if (pattern !== 16'h0005) $display("FAIL play_pattern: got %h expected 0005", pattern); else n_pass++;
    watch_play(step_start_cycle(16) + 1, 4'd0, exp_pat, 0, ph);
    run = 1'b0;
    tick();
    n_checks++; if (gate !== 1'b0) $display("FAIL pause_gate_wrap: got %b expected 0", gate); else n_pass++;
    n_checks++; if (playhead !== ph) $display("FAIL pause_keep_wrap: got %0d expected %0d", playhead, ph); else n_pass++;
    cur_ph = ph;
  endtask

  task automatic test_pause_resume();
    logic [3:0] ph;
    press(6);
    n_checks++; if (pattern !== 16'h0045) $display("FAIL pause_pattern: got %h expected 0045", pattern); else n_pass++;
    watch_play(step_start_cycle(6) + 1, cur_ph, exp_pat, 0, ph);
    run = 1'b0;
    tick();
    n_checks++; if (gate !== 1'b0) $display("FAIL pause_gate: got %b expected 0", gate); else n_pass++;
    n_checks++; if (step_pulse !== 1'b0) $display("FAIL pause_pulse: got %b expected 0", step_pulse); else n_pass++;
    n_checks++; if (playhead !== 4'd6) $display("FAIL pause_playhead: got %0d expected 6", playhead); else n_pass++;
    repeat (3) tick();
    n_checks++; if (playhead !== 4'd6 || gate !== 1'b0) $display("FAIL paused_hold: ph %0d gate %b expected 6 0", playhead, gate); else n_pass++;
    watch_play(12, 4'd6, exp_pat, 0, ph);
    run = 1'b0;
    tick();
    cur_ph = ph;
  endtask

  task automatic test_rewind();
    logic [3:0] ph;
    int boundary;
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    n_checks++; if (playhead !== 4'd0) $display("FAIL idle_rewind_ph: got %0d expected 0", playhead); else n_pass++;
    n_checks++; if (step_pulse !== 1'b0 || gate !== 1'b0) $display("FAIL idle_rewind_out: pulse %b gate %b expected 0 0", step_pulse, gate); else n_pass++;
    // Rewind lands on the edge that would otherwise end step 9.
    boundary = step_start_cycle(10);
    watch_play(boundary + step_len(0) + 2, 4'd0, exp_pat, boundary, ph);
    run = 1'b0;
    tick();
    cur_ph = ph;
  endtask

  task automatic test_reset_mid_gate();
    logic [3:0] ph;
    int waited = 0;
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    run = 1'b1;
    tick();
    while (gate !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_checks++; if (gate !== 1'b1) $display("FAIL reset_gate_wait: got %b expected 1", gate); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (gate !== 1'b0) $display("FAIL async_reset_gate: got %b expected 0", gate); else n_pass++;
    n_checks++; if (pattern !== 16'h0 || playhead !== 4'd0 || step_pulse !== 1'b0)
      $display("FAIL async_reset_outs: pat %h ph %0d pulse %b expected 0000 0 0", pattern, playhead, step_pulse);
    else n_pass++;
    run = 1'b0;
    exp_pat = '0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    n_checks++; if (step_pulse !== 1'b0 || gate !== 1'b0) $display("FAIL post_reset_idle: pulse %b gate %b expected 0 0", step_pulse, gate); else n_pass++;
    press(0);
    watch_play(10, 4'd0, exp_pat, 0, ph);
    run = 1'b0;
    tick();
    cur_ph = ph;
  endtask

  task automatic test_random_play();
    logic [3:0]  ph;
    logic [15:0] new_pat;
    int n, rw;
    for (int it = 0; it < 3; it++) begin
      do_clear();
      new_pat = 16'($urandom);
      for (int i = 0; i < 16; i++) if (new_pat[i]) press(i);
      n_checks++; if (pattern !== new_pat) $display("FAIL random_pattern %0d: got %h expected %h", it, pattern, new_pat); else n_pass++;
      n  = int'($urandom_range(40, 90));
      rw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0;
      watch_play(n, cur_ph, exp_pat, rw, ph);
      run = 1'b0;
      tick();
      n_checks++; if (gate !== 1'b0 || playhead !== ph) $display("FAIL random_pause %0d: gate %b ph %0d expected 0 %0d", it, gate, playhead, ph); else n_pass++;
      cur_ph = ph;
    end
  endtask

  task automatic test_step_period();
    int pulse_t[$];
    int gate_cnt[$];
    do_clear();
    for (int i = 0; i < 16; i++) press(i);
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    run = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (step_pulse === 1'b1) begin
        pulse_t.push_back(c);
        gate_cnt.push_back(0);
      end
      if (gate === 1'b1 && gate_cnt.size() > 0) gate_cnt[gate_cnt.size() - 1]++;
    end
    run = 1'b0;
    tick();
    n_checks++; if (pulse_t.size() < 5) $display("FAIL period_pulse_count: got %0d expected >= 5", pulse_t.size()); else n_pass++;
    for (int k = 1; k < pulse_t.size(); k++) begin
      n_checks++;
      if (pulse_t[k] - pulse_t[k-1] !== step_len((k - 1) % 16))
        $display("FAIL period_interval %0d: got %0d expected %0d", k, pulse_t[k] - pulse_t[k-1], step_len((k - 1) % 16));
      else n_pass++;
      n_checks++;
      if (gate_cnt[k-1] !== GATE) $display("FAIL period_gate_len %0d: got %0d expected %0d", k, gate_cnt[k-1], GATE);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; button_index = '0; button_pressed = 1'b0;
    run = 1'b0; clear = 1'b0; rewind = 1'b0;
    test_reset();
    test_toggle();
    test_play();
    test_pause_resume();
    test_rewind();
    test_reset_mid_gate();
    test_random_play();
    test_step_period();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
